// File: rtl/lmac_ctrl_pkg.sv
// Shared types and constants for the LMAC register-read arbiter.
// The optional read watchdog is enabled by defining LMAC_RD_TIMEOUT_EN.
package lmac_ctrl_pkg;

  localparam int unsigned LMAC_ADDR_W = 16;
  localparam int unsigned LMAC_DATA_W = 32;

  localparam logic [LMAC_DATA_W-1:0] LMAC_RD_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } lmac_rd_state_e;

endpackage

// File: rtl/lmac_rr_arb.sv
// Combinational rotating-priority picker: grants the first requester at or
// after ptr, searching upward with wrap-around.
module lmac_rr_arb #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    logic        found;
    int unsigned idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/lmac_reg_rd_arbiter.sv
// Round-robin sharing of the LMAC register-read port among NREQ requesters.
// Define LMAC_RD_TIMEOUT_EN to add a watchdog that aborts reads after TIMEOUT WAIT cycles.
module lmac_reg_rd_arbiter
  import lmac_ctrl_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*LMAC_ADDR_W-1:0]   req_addr,
  output logic [NREQ-1:0]               req_ready,
  output logic [NREQ-1:0]               rsp_valid,
  output logic [LMAC_DATA_W-1:0]        rsp_data,
  output logic                          rsp_err,
  output logic                          busy,
  output logic [LMAC_ADDR_W-1:0]        host_addr_reg,
  output logic                          reg_rd_start,
  input  logic                          reg_rd_done_out,
  input  logic [LMAC_DATA_W-1:0]        FMAC_REGDOUT
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  lmac_rd_state_e  state_q;
  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] gnt_idx_q;
  logic [NREQ-1:0] gnt_oh_q;
  logic [NREQ-1:0] arb_grant;
  logic [IdxW-1:0] arb_idx;
  logic            done_ok;

  lmac_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IdxW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // The strobe is still high in the first WAIT cycle; a done seen then cannot
  // belong to this read, so sampling starts one cycle later.
  assign done_ok = reg_rd_done_out & ~reg_rd_start;

`ifdef LMAC_RD_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);
  logic [15:0] cnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
  assign rsp_err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      gnt_idx_q     <= '0;
      gnt_oh_q      <= '0;
      req_ready     <= '0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
      busy          <= 1'b0;
      host_addr_reg <= '0;
      reg_rd_start  <= 1'b0;
`ifdef LMAC_RD_TIMEOUT_EN
      rsp_err       <= 1'b0;
      cnt_q         <= '0;
`endif
    end else begin
      req_ready    <= '0;
      rsp_valid    <= '0;
      reg_rd_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req_valid) begin
            req_ready     <= arb_grant;
            host_addr_reg <= req_addr[32'(arb_idx)*LMAC_ADDR_W +: LMAC_ADDR_W];
            gnt_idx_q     <= arb_idx;
            gnt_oh_q      <= arb_grant;
            busy          <= 1'b1;
            state_q       <= StIssue;
          end
        end
        StIssue: begin
          reg_rd_start <= 1'b1;
          state_q      <= StWait;
`ifdef LMAC_RD_TIMEOUT_EN
          cnt_q        <= '0;
`endif
        end
        StWait: begin
          if (done_ok) begin
            rsp_data  <= FMAC_REGDOUT;
            rsp_valid <= gnt_oh_q;
            state_q   <= StResp;
`ifdef LMAC_RD_TIMEOUT_EN
            rsp_err   <= 1'b0;
          end else if (cnt_q == TimeoutLast) begin
            rsp_data  <= LMAC_RD_TIMEOUT_DATA;
            rsp_err   <= 1'b1;
            rsp_valid <= gnt_oh_q;
            state_q   <= StResp;
          end else begin
            cnt_q <= cnt_q + 16'd1;
`endif
          end
        end
        StResp: begin
          ptr_q   <= (gnt_idx_q == IdxW'(NREQ - 1)) ? '0 : gnt_idx_q + IdxW'(1);
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
